// File: rtl/stk_pipe_ad.sv
// stk_pipe_ad: admission stage ahead of the stack allocator pipe.
//   Accepts ALLOC/DEALLOC commands. ALLOC pops a descriptor from the allocator.
//   The lookup stage returns the pointer one cycle later. Each ALLOC produces
//   one response, queued in a credit-controlled FIFO. DEALLOC returns a
//   descriptor directly to the allocator and produces no response.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_cmd_*/o_cmd_rdy               command handshake (op 0=ALLOC, 1=DEALLOC)
//   o_ad_alloc                      allocator pop strobe
//   i_ad_empty_r, i_ad_busy         allocator status
//   o_dealloc_vld/o_dealloc_ptr     descriptor return to allocator
//   i_lk_ptr_w                      allocated pointer, valid cycle after o_ad_alloc
//   o_rsp_*/i_rsp_rdy               response handshake
// Optional: define STK_PIPE_AD_STATS_EN to add saturating success/fail counters
//   o_stat_alloc_cnt and o_stat_err_cnt.
module stk_pipe_ad #(
  parameter int PTR_W   = 16,
  parameter int CTXT_W  = 4,
  parameter int RSP_Q_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_vld,
  input  logic              i_cmd_op,
  input  logic [CTXT_W-1:0] i_cmd_ctxt,
  input  logic [PTR_W-1:0]  i_cmd_ptr,
  output logic              o_cmd_rdy,
  output logic              o_ad_alloc,
  input  logic              i_ad_empty_r,
  input  logic              i_ad_busy,
  output logic              o_dealloc_vld,
  output logic [PTR_W-1:0]  o_dealloc_ptr,
  input  logic [PTR_W-1:0]  i_lk_ptr_w,
  output logic              o_rsp_vld,
  output logic [CTXT_W-1:0] o_rsp_ctxt,
  output logic [PTR_W-1:0]  o_rsp_ptr,
  output logic              o_rsp_err,
`ifdef STK_PIPE_AD_STATS_EN
  output logic [15:0]       o_stat_alloc_cnt,
  output logic [15:0]       o_stat_err_cnt,
`endif
  input  logic              i_rsp_rdy
);

  localparam int AW = (RSP_Q_N > 1) ? $clog2(RSP_Q_N) : 1;
  localparam int CW = $clog2(RSP_Q_N + 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  typedef struct packed {
    logic [CTXT_W-1:0] ctxt;
    logic [PTR_W-1:0]  ptr;
    logic              err;
  } rsp_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              lk_vld_q, lk_vld_d;
  logic              lk_err_q, lk_err_d;
  logic [CTXT_W-1:0] lk_ctxt_q, lk_ctxt_d;
  rsp_t              mem_q [RSP_Q_N];
  rsp_t              mem_d [RSP_Q_N];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic acc, alloc_acc, push, pop;
  rsp_t head, push_ent;

  always_comb begin
    // Ready never depends on the command itself; rst gates it so nothing
    // is accepted in the cycle that the flush happens.
    o_cmd_rdy     = ~rst & (state_q == S_RUN) & ~i_ad_busy & (credit_q != '0);
    acc           = i_cmd_vld & o_cmd_rdy;
    alloc_acc     = acc & ~i_cmd_op;
    o_ad_alloc    = alloc_acc & ~i_ad_empty_r;
    o_dealloc_vld = acc & i_cmd_op;
    o_dealloc_ptr = o_dealloc_vld ? i_cmd_ptr : '0;

    head       = mem_q[rd_ptr_q];
    o_rsp_vld  = (cnt_q != '0);
    o_rsp_ctxt = o_rsp_vld ? head.ctxt : '0;
    o_rsp_ptr  = o_rsp_vld ? head.ptr  : '0;
    o_rsp_err  = o_rsp_vld ? head.err  : 1'b0;
    pop        = o_rsp_vld & i_rsp_rdy;

    // Lookup slot: the pointer arrives the cycle after the alloc strobe.
    // An empty-pool fail rides the same slot so responses keep accept order.
    push          = lk_vld_q;
    push_ent.ctxt = lk_ctxt_q;
    push_ent.ptr  = lk_err_q ? '0 : i_lk_ptr_w;
    push_ent.err  = lk_err_q;

    state_d = state_q;
    if (state_q == S_INIT && !i_ad_busy) state_d = S_RUN;

    lk_vld_d  = alloc_acc;
    lk_err_d  = i_ad_empty_r;
    lk_ctxt_d = i_cmd_ctxt;

    credit_d = credit_q;
    if (alloc_acc && !pop) credit_d = credit_q - CW'(1);
    if (!alloc_acc && pop) credit_d = credit_q + CW'(1);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      credit_q  <= CW'(RSP_Q_N);
      lk_vld_q  <= 1'b0;
      lk_err_q  <= 1'b0;
      lk_ctxt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      lk_vld_q  <= lk_vld_d;
      lk_err_q  <= lk_err_d;
      lk_ctxt_q <= lk_ctxt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef STK_PIPE_AD_STATS_EN
  logic [15:0] alloc_cnt_q, alloc_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    alloc_cnt_d = alloc_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (o_ad_alloc && alloc_cnt_q != 16'hFFFF)                alloc_cnt_d = alloc_cnt_q + 16'd1;
    if (alloc_acc && i_ad_empty_r && err_cnt_q != 16'hFFFF) err_cnt_d   = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      alloc_cnt_q <= alloc_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_stat_alloc_cnt = alloc_cnt_q;
  assign o_stat_err_cnt   = err_cnt_q;
`endif

endmodule
